// File: rtl/crc_dma_pkg.sv
// Shared constants for the CRC DMA feeder: register map, CTL bit positions,
// FSM state encodings and the fixed master access size.
package crc_dma_pkg;

    localparam logic [3:0] OFF_SRC = 4'h0;
    localparam logic [3:0] OFF_LEN = 4'h4;
    localparam logic [3:0] OFF_CTL = 4'h8;
    localparam logic [3:0] OFF_CNT = 4'hC;

    localparam int CTL_START = 0;
    localparam int CTL_BUSY  = 1;
    localparam int CTL_DONE  = 2;
    localparam int CTL_INC   = 3;
    localparam int CTL_IE    = 4;
    localparam int CTL_ABORT = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WREQ  = 3'd1;
    localparam logic [2:0] ST_GUARD = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    localparam logic [1:0] M_SIZE_WORD = 2'b10;

    // Bit shift that aligns a 32-bit register with the addressed byte lane.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/crc_dma.sv
// Single-channel memory-to-CRC DMA feeder: fetches words over the bus master
// port and hands them to the CRC engine one per p_req/p_ack handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; SRC/LEN writable
// WREQ     | waiting for the CRC engine to raise p_req
// FETCH    | master read in flight; m_valid/m_addr held until m_ready
// ACK      | one-cycle p_ack with the fetched word, count/address update
// GUARD    | one cycle ignoring p_req so a stale request is not reused
module crc_dma
    import crc_dma_pkg::*;
#(
    parameter int LW = 16
) (
    input  logic        c_clk,
    input  logic        c_rstb,
    input  logic        c_valid,
    input  logic        c_write,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_wdata,
    output logic        c_ready,
    output logic [31:0] c_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [1:0]  m_size,
    output logic        m_write,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    input  logic        p_req,
    output logic        p_ack,
    output logic [31:0] p_data,
    output logic        irq
);

    logic [2:0]    state;
    logic [31:0]   src;
    logic [31:0]   addr;
    logic [31:0]   buffer;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;
    logic          done;
    logic          inc;
    logic          ie;
    logic          abort_pend;

    logic          busy;
    logic          access;
    logic          wr;
    logic [4:0]    sh;
    logic [31:0]   wdata_s;
    logic [31:0]   rd_word;
    logic [31:0]   ctl_rd;
    logic [3:0]    off;
    logic          sel_src;
    logic          sel_len;
    logic          sel_ctl;
    logic          start_w;
    logic          abort_w;
    logic          done_w1c;
    logic          unused_bits;

    assign busy     = (state != ST_IDLE);
    assign access   = c_valid & ~c_ready;
    assign wr       = access & c_write;
    assign sh       = lane_shift(c_addr[1:0]);
    assign wdata_s  = c_wdata << sh;
    assign off      = {c_addr[3:2], 2'b00};
    assign sel_src  = wr & (off == OFF_SRC);
    assign sel_len  = wr & (off == OFF_LEN);
    assign sel_ctl  = wr & (off == OFF_CTL);
    // Abort written together with start suppresses the start.
    assign abort_w  = sel_ctl & wdata_s[CTL_ABORT];
    assign start_w  = sel_ctl & wdata_s[CTL_START] & ~wdata_s[CTL_ABORT];
    assign done_w1c = sel_ctl & wdata_s[CTL_DONE];

    assign m_valid  = (state == ST_FETCH);
    assign m_addr   = m_valid ? addr : 32'h0;
    assign m_size   = M_SIZE_WORD;
    assign m_write  = 1'b0;
    assign p_ack    = (state == ST_ACK);
    assign p_data   = buffer;
    assign irq      = done & ie;

    assign unused_bits = ^{c_size, c_addr[31:4]};

    always_comb begin
        ctl_rd            = 32'h0;
        ctl_rd[CTL_BUSY]  = busy;
        ctl_rd[CTL_DONE]  = done;
        ctl_rd[CTL_INC]   = inc;
        ctl_rd[CTL_IE]    = ie;
    end

    always_comb begin
        rd_word = 32'h0;
        case (off)
            OFF_SRC: rd_word = src;
            OFF_LEN: rd_word = 32'(len);
            OFF_CTL: rd_word = ctl_rd;
            OFF_CNT: rd_word = 32'(cnt);
            default: rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge c_clk or negedge c_rstb) begin
        if (!c_rstb) begin
            c_ready <= 1'b0;
            c_rdata <= 32'h0;
            src     <= 32'h0;
            len     <= '0;
            inc     <= 1'b1;
            ie      <= 1'b0;
        end else begin
            c_ready <= c_valid;
            c_rdata <= (access && !c_write) ? (rd_word >> sh) : 32'h0;
            if (sel_src && !busy) begin
                src <= {wdata_s[31:2], 2'b00};
            end
            if (sel_len && !busy) begin
                len <= wdata_s[LW-1:0];
            end
            if (sel_ctl) begin
                inc <= wdata_s[CTL_INC];
                ie  <= wdata_s[CTL_IE];
            end
        end
    end

    always_ff @(posedge c_clk or negedge c_rstb) begin
        if (!c_rstb) begin
            state      <= ST_IDLE;
            addr       <= 32'h0;
            cnt        <= '0;
            buffer     <= 32'h0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            // Hardware set of done below takes priority over a W1C in the same cycle.
            if (done_w1c) begin
                done <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (start_w) begin
                        addr <= src;
                        cnt  <= len;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            state <= ST_WREQ;
                        end
                    end
                end
                ST_WREQ: begin
                    if (abort_w) begin
                        state <= ST_IDLE;
                    end else if (p_req) begin
                        state <= ST_FETCH;
                    end
                end
                ST_GUARD: begin
                    state <= abort_w ? ST_IDLE : ST_WREQ;
                end
                ST_FETCH: begin
                    if (abort_w) begin
                        abort_pend <= 1'b1;
                    end
                    // The bus transfer always completes; an abort only discards its data.
                    if (m_ready) begin
                        abort_pend <= 1'b0;
                        if (abort_w || abort_pend) begin
                            state <= ST_IDLE;
                        end else begin
                            buffer <= m_rdata;
                            state  <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    cnt <= cnt - LW'(1);
                    if (inc) begin
                        addr <= addr + 32'd4;
                    end
                    if (cnt == LW'(1)) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= abort_w ? ST_IDLE : ST_GUARD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_dma.sv
// Directed bench for crc_dma: a transfer-level model predicts fetch addresses
// and delivered words, and one monitor checks the DUT against it every cycle.
module tb_crc_dma;

    logic        c_clk = 1'b0;
    logic        c_rstb = 1'b0;
    logic        c_valid;
    logic        c_write;
    logic [31:0] c_addr;
    logic [1:0]  c_size;
    logic [31:0] c_wdata;
    logic        c_ready;
    logic [31:0] c_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic        m_write;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        p_req;
    logic        p_ack;
    logic [31:0] p_data;
    logic        irq;

    always #5 c_clk = ~c_clk;

    crc_dma #(.LW(16)) dut (
        .c_clk(c_clk), .c_rstb(c_rstb),
        .c_valid(c_valid), .c_write(c_write), .c_addr(c_addr), .c_size(c_size),
        .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_write(m_write),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .p_req(p_req), .p_ack(p_ack), .p_data(p_data), .irq(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];

    int mem_delay    = 0;
    bit steady       = 1'b0;
    int xfer_len     = 0;
    int ack_total    = 0;
    int mv_total     = 0;
    int acks_in_xfer = 0;
    int last_ack_cyc = 0;
    int first_mv_cyc = -1;
    int acc_cyc      = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory slave: ready follows a pending request after mem_delay extra cycles.
    initial begin
        bit sv;
        int wc;
        m_ready = 1'b0;
        m_rdata = 32'h0;
        sv = 1'b0;
        wc = 0;
        forever begin
            @(negedge c_clk);
            sv = m_valid && !m_ready;
            @(posedge c_clk);
            #1;
            if (!c_rstb) begin
                m_ready = 1'b0;
                wc = 0;
            end else if (m_ready) begin
                m_ready = 1'b0;
            end else if (sv) begin
                if (wc >= mem_delay) begin
                    m_ready = 1'b1;
                    m_rdata = mem[m_addr[11:2]];
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
    end

    // Monitor: compares bus and peripheral activity against the model queues.
    initial begin
        logic        mv_prev;
        logic        ack_prev;
        logic        irq_prev;
        logic [31:0] held;
        logic [31:0] last_data;
        int          run;
        mv_prev = 0; ack_prev = 0; irq_prev = 0; held = 0; last_data = 0; run = 0;
        forever begin
            @(negedge c_clk);
            if (!c_rstb) begin
                mv_prev = 0; ack_prev = 0; irq_prev = 0; last_data = 0; run = 0;
            end else begin
                if (m_valid && !mv_prev) begin
                    mv_total++;
                    if (first_mv_cyc < 0) first_mv_cyc = cyc;
                    addr_log.push_back(m_addr);
                    if (exp_addr.size() == 0) chk("fetch_expected", 32'(exp_addr.size()), 1);
                    else chk("m_addr", m_addr, exp_addr.pop_front());
                    chk("m_size", {30'h0, m_size}, 32'h2);
                    held = m_addr;
                    run = 1;
                end else if (m_valid) begin
                    chk("m_addr_stable", m_addr, held);
                    run++;
                end else if (mv_prev) begin
                    chk("m_valid_len", run, mem_delay + 2);
                end
                if (p_ack) begin
                    chk("p_ack_width", {31'h0, ack_prev}, 0);
                    ack_total++;
                    data_log.push_back(p_data);
                    if (exp_data.size() == 0) chk("ack_expected", 32'(exp_data.size()), 1);
                    else chk("p_data", p_data, exp_data.pop_front());
                    if (steady && acks_in_xfer > 0) chk("ack_period", cyc - last_ack_cyc, 5);
                    acks_in_xfer++;
                    last_ack_cyc = cyc;
                    last_data = p_data;
                end else begin
                    chk("p_data_hold", p_data, last_data);
                end
                if (irq && !irq_prev && xfer_len > 0) chk("irq_after_ack", cyc - last_ack_cyc, 1);
                mv_prev = m_valid;
                ack_prev = p_ack;
                irq_prev = irq;
            end
        end
    end

    task automatic reg_write(input logic [3:0] off, input logic [31:0] d);
        @(posedge c_clk); #1;
        c_valid = 1'b1; c_write = 1'b1; c_addr = {28'h0, off}; c_wdata = d;
        acc_cyc = cyc;
        @(posedge c_clk); #1;
        c_valid = 1'b0; c_write = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] off, output logic [31:0] d);
        @(posedge c_clk); #1;
        c_valid = 1'b1; c_write = 1'b0; c_addr = {28'h0, off};
        @(posedge c_clk); #1;
        c_valid = 1'b0;
        d = c_rdata;
    endtask

    task automatic read_chk(input string name, input logic [3:0] off, input logic [31:0] req);
        logic [31:0] d;
        reg_read(off, d);
        chk(name, d, req);
    endtask

    task automatic start_xfer(input logic [31:0] src, input int len, input bit inc);
        reg_write(4'h0, src);
        reg_write(4'h4, 32'(len));
        for (int i = 0; i < len; i++) begin
            logic [31:0] a;
            a = src + (inc ? 32'(4 * i) : 32'h0);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a[11:2]]);
        end
        xfer_len = len;
        acks_in_xfer = 0;
        first_mv_cyc = -1;
        addr_log.delete();
        data_log.delete();
        reg_write(4'h8, 32'h11 | (inc ? 32'h8 : 32'h0));
    endtask

    task automatic wait_irq(input int max, input string name);
        int n = 0;
        while (!irq && n < max) begin
            @(posedge c_clk); #1;
            n++;
        end
        chk(name, {31'h0, irq}, 1);
    endtask

    task automatic wait_mvalid(input int max, input string name);
        int n = 0;
        while (!m_valid && n < max) begin
            @(posedge c_clk); #1;
            n++;
        end
        chk(name, {31'h0, m_valid}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv0;
        int a0;
        int n;
        c_valid = 0; c_write = 0; c_addr = 0; c_wdata = 0; c_size = 2'b10; p_req = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + 32'(i * 3);
        mem[64] = 32'hA; mem[65] = 32'hB; mem[66] = 32'hC;

        // Reset
        repeat (3) @(posedge c_clk);
        #2;
        chk("rst_m_valid", {31'h0, m_valid}, 0);
        chk("rst_p_ack", {31'h0, p_ack}, 0);
        chk("rst_m_size", {30'h0, m_size}, 32'h2);
        @(negedge c_clk);
        c_rstb = 1'b1;
        read_chk("rst_src", 4'h0, 32'h0);
        read_chk("rst_len", 4'h4, 32'h0);
        read_chk("rst_ctl", 4'h8, 32'h08);
        read_chk("rst_cnt", 4'hC, 32'h0);
        chk("rst_irq", {31'h0, irq}, 0);
        chk("rst_m_write", {31'h0, m_write}, 0);

        // Basic three-word transfer
        p_req = 1'b1; steady = 1'b1; mem_delay = 0;
        start_xfer(32'h100, 3, 1'b1);
        wait_irq(100, "basic_done");
        chk("start_latency_ge2", 32'(first_mv_cyc - acc_cyc >= 2), 1);
        chk("basic_acks", acks_in_xfer, 3);
        chk("basic_addr0", addr_log[0], 32'h100);
        chk("basic_addr1", addr_log[1], 32'h104);
        chk("basic_addr2", addr_log[2], 32'h108);
        chk("basic_data0", data_log[0], 32'hA);
        chk("basic_data1", data_log[1], 32'hB);
        chk("basic_data2", data_log[2], 32'hC);
        read_chk("basic_ctl", 4'h8, 32'h1C);
        read_chk("basic_cnt", 4'hC, 32'h0);
        chk("basic_irq", {31'h0, irq}, 1);
        chk("basic_drained", 32'(exp_data.size()), 0);

        // Peripheral backpressure
        steady = 1'b0; p_req = 1'b0;
        start_xfer(32'h200, 2, 1'b1);
        mv0 = mv_total; a0 = ack_total;
        repeat (20) @(posedge c_clk);
        #1;
        chk("preq_low_no_fetch", mv_total - mv0, 0);
        chk("preq_low_no_ack", ack_total - a0, 0);
        read_chk("preq_low_ctl", 4'h8, 32'h1A);
        p_req = 1'b1;
        wait_irq(200, "preq_done");
        chk("preq_acks", acks_in_xfer, 2);
        chk("preq_drained", 32'(exp_data.size()), 0);

        // Memory backpressure
        mem_delay = 5;
        mv0 = mv_total;
        start_xfer(32'h300, 1, 1'b1);
        wait_irq(200, "membp_done");
        chk("membp_acks", acks_in_xfer, 1);
        chk("membp_fetches", mv_total - mv0, 1);
        chk("membp_data", data_log[0], mem[32'h300 >> 2]);

        // Abort during the second fetch
        mem_delay = 3;
        start_xfer(32'h400, 4, 1'b1);
        n = 0;
        while (acks_in_xfer < 1 && n < 200) begin
            @(posedge c_clk); #1;
            n++;
        end
        chk("abort_first_ack", acks_in_xfer, 1);
        wait_mvalid(50, "abort_second_fetch");
        reg_write(4'h8, 32'h38);
        repeat (20) @(posedge c_clk);
        #1;
        chk("abort_acks", acks_in_xfer, 1);
        chk("abort_no_more_fetch", 32'(exp_addr.size()), 2);
        read_chk("abort_cnt", 4'hC, 32'h3);
        read_chk("abort_ctl", 4'h8, 32'h18);
        chk("abort_irq", {31'h0, irq}, 0);
        exp_addr.delete();
        exp_data.delete();

        // LEN = 0
        mem_delay = 0;
        mv0 = mv_total;
        chk("len0_irq_before", {31'h0, irq}, 0);
        start_xfer(32'h600, 0, 1'b1);
        chk("len0_done", {31'h0, irq}, 1);
        repeat (5) @(posedge c_clk);
        #1;
        chk("len0_no_fetch", mv_total - mv0, 0);
        read_chk("len0_ctl", 4'h8, 32'h1C);

        // inc = 0: both fetches at SRC
        steady = 1'b1;
        start_xfer(32'h500, 2, 1'b0);
        wait_irq(100, "noinc_done");
        chk("noinc_acks", acks_in_xfer, 2);
        chk("noinc_addr0", addr_log[0], 32'h500);
        chk("noinc_addr1", addr_log[1], 32'h500);

        // Reset in the middle of a fetch
        steady = 1'b0; mem_delay = 5;
        start_xfer(32'h100, 2, 1'b1);
        wait_mvalid(50, "rstmid_fetch");
        @(posedge c_clk);
        #3;
        c_rstb = 1'b0;
        #1;
        chk("rstmid_m_valid", {31'h0, m_valid}, 0);
        chk("rstmid_m_addr", m_addr, 32'h0);
        chk("rstmid_p_ack", {31'h0, p_ack}, 0);
        chk("rstmid_p_data", p_data, 32'h0);
        chk("rstmid_irq", {31'h0, irq}, 0);
        chk("rstmid_c_ready", {31'h0, c_ready}, 0);
        chk("rstmid_c_rdata", c_rdata, 32'h0);
        chk("rstmid_m_size", {30'h0, m_size}, 32'h2);
        repeat (2) @(negedge c_clk);
        exp_addr.delete();
        exp_data.delete();
        c_rstb = 1'b1;
        read_chk("rstmid_ctl", 4'h8, 32'h08);
        read_chk("rstmid_cnt", 4'hC, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
